// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, and emit
// press / release / long-press pulses per channel.
module button_conditioner #(
   parameter int N_BTN             = 2,
   parameter int DEBOUNCE_CYCLES   = 120000,
   parameter int LONG_PRESS_CYCLES = 12000000,
   parameter bit ACTIVE_LOW        = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   // state       | meaning
   // RELEASED    | debounced level is 0, waiting for s=1
   // ARM_PRESS   | s=1 seen, counting stable cycles toward a press
   // PRESSED     | debounced level is 1, long-press timer running
   // ARM_RELEASE | s=0 seen, counting stable cycles toward a release
   typedef enum logic [1:0] {
      ST_RELEASED    = 2'd0,
      ST_ARM_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_ARM_RELEASE = 2'd3
   } state_e;

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int LW = $clog2(LONG_PRESS_CYCLES) + 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
   localparam logic [LW-1:0] LP_PRE  = LW'(LONG_PRESS_CYCLES - 2);

   // Synchroniser holds raw pin polarity, so its idle value is the released level.
   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= {N_BTN{ACTIVE_LOW}};
         sync2_q <= {N_BTN{ACTIVE_LOW}};
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

   for (genvar ch = 0; ch < N_BTN; ch++) begin : g_ch
      state_e          state_q, state_d;
      logic [DW-1:0]   db_q, db_d;
      logic [LW-1:0]   lp_q, lp_d;
      logic            level_q, level_d;
      logic            press_q, press_d;
      logic            rel_q, rel_d;
      logic            long_q, long_d;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_RELEASED;
            db_q    <= '0;
            lp_q    <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            db_q    <= db_d;
            lp_q    <= lp_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
         end
      end

      always_comb begin
         state_d = state_q;
         db_d    = db_q;
         lp_d    = lp_q;
         level_d = level_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         long_d  = 1'b0;
         // Long-press timer keeps running through release bounces and saturates.
         if (state_q == ST_PRESSED || state_q == ST_ARM_RELEASE) begin
            if (lp_q != LP_LAST) lp_d = lp_q + 1'b1;
            long_d = (lp_q == LP_PRE);
         end
         case (state_q)
            ST_RELEASED: begin
               level_d = 1'b0;
               lp_d    = '0;
               if (s[ch]) begin
                  state_d = ST_ARM_PRESS;
                  db_d    = '0;
               end
            end
            ST_ARM_PRESS: begin
               if (!s[ch]) begin
                  state_d = ST_RELEASED;
               end else if (db_q == DB_LAST) begin
                  state_d = ST_PRESSED;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  lp_d    = '0;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!s[ch]) begin
                  state_d = ST_ARM_RELEASE;
                  db_d    = '0;
               end
            end
            ST_ARM_RELEASE: begin
               if (s[ch]) begin
                  state_d = ST_PRESSED;
               end else if (db_q == DB_LAST) begin
                  state_d = ST_RELEASED;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
               end else begin
                  db_d = db_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_RELEASED;
               db_d    = '0;
               lp_d    = '0;
               level_d = 1'b0;
               long_d  = 1'b0;
            end
         endcase
      end

      assign btn_level[ch]   = level_q;
      assign btn_press[ch]   = press_q;
      assign btn_release[ch] = rel_q;
      assign btn_long[ch]    = long_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce / long-press timing.
module tb_button_conditioner;
   localparam int N = 2;
   localparam int D = 4;
   localparam int L = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] raw;
   logic [N-1:0] level, press, rel, lng;
   int           n_chk  = 0;
   int           n_pass = 0;

   button_conditioner #(
      .N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(raw),
      .btn_level(level), .btn_press(press), .btn_release(rel), .btn_long(lng)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
   endtask

   // Returns #1 after a rising edge, so outputs reflect that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      raw = 2'b11;
      repeat (n) step();
   endtask

   initial begin
      rst = 1'b1;
      raw = 2'b11;
      repeat (2) step();
      check("reset_level", level, 2'b00);
      check("reset_press", press, 2'b00);
      #2 rst = 1'b0;
      idle(3);
      check("idle_level", level, 2'b00);
      check("idle_events", press | rel | lng, 2'b00);

      // Basic press on channel 0, held for a long press, then released.
      raw = 2'b10;
      for (int k = 0; k <= 36; k++) begin
         step();
         check("t1_press", press, (k == 6) ? 2'b01 : 2'b00);
         check("t1_level", level, (k >= 6) ? 2'b01 : 2'b00);
         check("t1_long", lng, (k == 25) ? 2'b01 : 2'b00);
         check("t1_rel", rel, 2'b00);
      end
      raw = 2'b11;
      for (int j = 0; j <= 8; j++) begin
         step();
         check("t1_release", rel, (j == 6) ? 2'b01 : 2'b00);
         check("t1_rlevel", level, (j < 6) ? 2'b01 : 2'b00);
         check("t1_rlong", lng | press, 2'b00);
      end
      idle(4);

      // Two-cycle glitch must not confirm.
      raw = 2'b10;
      for (int k = 0; k <= 12; k++) begin
         step();
         if (k == 1) raw = 2'b11;
         check("t2_press", press, 2'b00);
         check("t2_level", level, 2'b00);
      end
      idle(4);

      // Release bounce after confirmation: no release, long timer unaffected.
      raw = 2'b10;
      for (int k = 0; k <= 30; k++) begin
         step();
         check("t3_level", level, (k >= 6) ? 2'b01 : 2'b00);
         check("t3_rel", rel, 2'b00);
         check("t3_long", lng, (k == 25) ? 2'b01 : 2'b00);
         if (k == 7) raw = 2'b11;
         if (k == 9) raw = 2'b10;
      end
      raw = 2'b11;
      for (int j = 0; j <= 8; j++) begin
         step();
         check("t3_release", rel, (j == 6) ? 2'b01 : 2'b00);
      end
      idle(4);

      // Both channels on the same edge.
      raw = 2'b00;
      for (int k = 0; k <= 8; k++) begin
         step();
         check("t4_press", press, (k == 6) ? 2'b11 : 2'b00);
         check("t4_level", level, (k >= 6) ? 2'b11 : 2'b00);
      end
      raw = 2'b11;
      for (int j = 0; j <= 8; j++) begin
         step();
         check("t4_release", rel, (j == 6) ? 2'b11 : 2'b00);
      end
      idle(4);

      // Reset mid-debounce and mid-press with the pin still held.
      raw = 2'b10;
      for (int k = 0; k <= 2; k++) step();
      #2 rst = 1'b1;
      #1 check("t5_rst_db", level | press | rel | lng, 2'b00);
      step();
      #2 rst = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         step();
         check("t5_press", press, (k == 6) ? 2'b01 : 2'b00);
         check("t5_level", level, (k >= 6) ? 2'b01 : 2'b00);
      end
      #2 rst = 1'b1;
      #1 check("t5_rst_level", level, 2'b00);
      check("t5_rst_events", press | rel | lng, 2'b00);
      step();
      check("t5_hold_level", level, 2'b00);
      #2 rst = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         step();
         check("t6_press", press, (k == 6) ? 2'b01 : 2'b00);
         check("t6_level", level, (k >= 6) ? 2'b01 : 2'b00);
         check("t6_rel", rel | lng, 2'b00);
      end
      idle(10);
      check("end_level", level, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
